main: RTL and testbench
=======================

MAIN -- requirements
Module: main

Interface
REQ-001 Parameter CLK_DIV, default 50: clocks per shift tick; legal range 1..65535.
REQ-002 Parameter WIDTH, default 5: LFSR length in bits; legal range 2..8.
REQ-003 Parameter TAPS, default 8'h14: feedback tap mask; only bits [WIDTH-1:0] are used.
REQ-004 Parameter SEED, default 8'h01: LFSR reset value; only bits [WIDTH-1:0] are used.
REQ-005 CLK_50MHZ  input  1: the single clock; all logic triggers on its rising edge.
REQ-006 RST_N  input  1: reset; asynchronous assert, active-low.
REQ-007 out_fun  output  1: serial M-sequence bit.
REQ-008 data  output  8: current LFSR state, zero-extended.

Function
REQ-009 The prescaler counter SHALL count 0..CLK_DIV-1 and wrap to 0; tick is asserted while the counter equals CLK_DIV-1.
REQ-010 When CLK_DIV=1, tick SHALL be asserted on every clock.
REQ-011 Feedback SHALL be the XOR reduction of state[WIDTH-1:0] AND TAPS[WIDTH-1:0].
REQ-012 On a clock edge with tick asserted, state SHALL become {state[WIDTH-2:0], feedback}; without tick, state SHALL hold.
REQ-013 out_fun SHALL equal state[WIDTH-1], driven directly from the register with no combinational path from inputs.
REQ-014 data[WIDTH-1:0] SHALL equal state; data[7:WIDTH] SHALL be 0.
REQ-015 The first state update after reset release SHALL occur on the CLK_DIV-th rising edge.
REQ-016 With the defaults (x^5+x^3+1), the sequence period SHALL be 31 ticks, with 16 ones and 15 zeros per period on out_fun.
REQ-017 Without lockup recovery, an all-zero state SHALL persist indefinitely.

Reset
REQ-018 While RST_N=0, the prescaler SHALL be 0 and state SHALL be SEED[WIDTH-1:0].
REQ-019 During reset, data SHALL equal the zero-extended SEED and out_fun SHALL equal SEED[WIDTH-1].
REQ-020 Asserting reset mid-sequence SHALL abort the sequence immediately; after release, counting SHALL restart from the seed per REQ-015.

Configuration
REQ-021 The macro MAIN_LOCKUP_RECOVERY_EN SHALL control all-zero lockup recovery.
REQ-022 With MAIN_LOCKUP_RECOVERY_EN defined, an all-zero state at a tick SHALL load SEED[WIDTH-1:0] instead of shifting.
REQ-023 If SEED[WIDTH-1:0] is also zero, the load value in REQ-022 SHALL be 1.
REQ-024 With MAIN_LOCKUP_RECOVERY_EN undefined, REQ-017 SHALL apply and no recovery logic SHALL be present.

Structure
REQ-025 Package main_pkg SHALL hold the default constants (DEF_CLK_DIV=50, DEF_WIDTH=5, DEF_TAPS=8'h14, DEF_SEED=8'h01) and the maximum width constant MAX_WIDTH=8.
REQ-026 The prescaler SHALL be the separate sub-module main_prescaler, which outputs tick.
REQ-027 The LFSR and output registers SHALL reside in main.

Verification
REQ-028 Defaults, release reset, observe 5 ticks -> data = 0x01, 0x02, 0x04, 0x09, 0x12, 0x05.
REQ-029 Defaults, capture out_fun over 62 ticks -> second 31 bits identical to first 31; data returns to 0x01 after exactly 31 ticks; data never 0x00.
REQ-030 CLK_DIV=50, measure edges between consecutive data changes -> exactly 50 clocks; first change on the 50th edge after release.
REQ-031 Assert RST_N low for one clock mid-sequence (asynchronously, between edges) -> data = 0x01 immediately; sequence restarts per REQ-028.
REQ-032 SEED=8'h00 with MAIN_LOCKUP_RECOVERY_EN defined -> data = 0x01 after the first tick, then 0x02.
REQ-033 SEED=8'h00 with MAIN_LOCKUP_RECOVERY_EN undefined -> data stays 0x00 and out_fun stays 0.

Source files
------------

// File: rtl/main_pkg.sv
// Shared constants and helpers for the M-sequence generator.
// The optional lockup recovery is selected by the MAIN_LOCKUP_RECOVERY_EN macro.
package main_pkg;

  localparam int           DEF_CLK_DIV = 50;
  localparam int           DEF_WIDTH   = 5;
  localparam logic [7:0]   DEF_TAPS    = 8'h14;
  localparam logic [7:0]   DEF_SEED    = 8'h01;
  localparam int           MAX_WIDTH   = 8;

  // A divide-by-one prescaler still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/main_prescaler.sv
// Free-running prescaler: counts 0..CLK_DIV-1 and flags the last count as tick.
module main_prescaler
  import main_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/main.sv
// Fibonacci LFSR M-sequence generator advanced by a prescaled tick.
// Define MAIN_LOCKUP_RECOVERY_EN to reload the seed when the state falls to all-zero.
module main
  import main_pkg::*;
#(
  parameter int         CLK_DIV = DEF_CLK_DIV,
  parameter int         WIDTH   = DEF_WIDTH,
  parameter logic [7:0] TAPS    = DEF_TAPS,
  parameter logic [7:0] SEED    = DEF_SEED
) (
  input  logic                 CLK_50MHZ,
  input  logic                 RST_N,
  output logic                 out_fun,
  output logic [MAX_WIDTH-1:0] data
);

  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_VAL = SEED[WIDTH-1:0];

  logic             tick;
  logic             feedback;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;

  main_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk  (CLK_50MHZ),
    .rst_n(RST_N),
    .tick (tick)
  );

  assign feedback = ^(state & TAP_MASK);

`ifdef MAIN_LOCKUP_RECOVERY_EN
  // An all-zero seed would relock immediately, so recovery falls back to 1.
  localparam logic [WIDTH-1:0] RECOVER_VAL = (SEED_VAL == '0) ? WIDTH'(1) : SEED_VAL;

  always_comb begin
    next_state = {state[WIDTH-2:0], feedback};
    if (state == '0) begin
      next_state = RECOVER_VAL;
    end
  end
`else
  always_comb begin
    next_state = {state[WIDTH-2:0], feedback};
  end
`endif

  // NOTE: state resets to the seed, not zero, so the sequence starts without lockup.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state <= SEED_VAL;
    end else if (tick) begin
      state <= next_state;
    end
  end

  assign out_fun = state[WIDTH-1];
  assign data    = MAX_WIDTH'(state);

endmodule

// File: tb/tb_main.sv
// Directed bench for main: reset, tick timing, full period, async reset, CLK_DIV=1, zero seed.
module tb_main;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       out_a, out_b, out_z;
  logic [7:0] data_a, data_b, data_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  main dut (
    .CLK_50MHZ(clk), .RST_N(rst_n), .out_fun(out_a), .data(data_a)
  );

  main #(.CLK_DIV(1)) dut_fast (
    .CLK_50MHZ(clk), .RST_N(rst_n), .out_fun(out_b), .data(data_b)
  );

  main #(.CLK_DIV(2), .SEED(8'h00)) dut_zero (
    .CLK_50MHZ(clk), .RST_N(rst_n), .out_fun(out_z), .data(data_z)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (data_a !== 8'h01) begin errors++; $display("FAIL reset_data: got %h want 01", data_a); end
    checks++;
    if (out_a !== 1'b0) begin errors++; $display("FAIL reset_out_fun: got %b want 0", out_a); end
    checks++;
    if (data_z !== 8'h00) begin errors++; $display("FAIL reset_zero_seed: got %h want 00", data_z); end
    @(posedge clk);
    #1;
    checks++;
    if (data_a !== 8'h01 || data_b !== 8'h01) begin
      errors++;
      $display("FAIL reset_hold: got %h/%h want 01/01", data_a, data_b);
    end
  endtask

  task automatic test_first_ticks();
    logic [7:0] exp_seq [4] = '{8'h04, 8'h09, 8'h12, 8'h05};
    logic [7:0] prev;
    int bad_edge;
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    bad_edge = 0;
    for (int i = 1; i <= 49; i++) begin
      @(posedge clk);
      #1;
      if (data_a !== 8'h01 && bad_edge == 0) bad_edge = i;
    end
    checks++;
    if (bad_edge != 0) begin errors++; $display("FAIL early_update: changed at edge %0d want edge 50", bad_edge); end
    @(posedge clk);
    #1;
    checks++;
    if (data_a !== 8'h02) begin errors++; $display("FAIL first_tick: got %h want 02 at edge 50", data_a); end
    for (int k = 0; k < 4; k++) begin
      prev = data_a;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (data_a === prev && n < 100);
      checks++;
      if (n != 50) begin errors++; $display("FAIL tick_spacing%0d: got %0d edges want 50", k, n); end
      checks++;
      if (data_a !== exp_seq[k]) begin errors++; $display("FAIL tick_value%0d: got %h want %h", k, data_a, exp_seq[k]); end
    end
  endtask

  task automatic test_period();
    logic [4:0]  model;
    logic [61:0] bits;
    int model_bad, zero_seen, first_return, ones;
    apply_reset();
    model = 5'h01;
    model_bad = -1;
    zero_seen = 0;
    first_return = -1;
    for (int t = 0; t < 62; t++) begin
      repeat (50) @(posedge clk);
      #1;
      model = {model[3:0], model[4] ^ model[2]};
      if (data_a !== {3'b000, model} && model_bad < 0) model_bad = t;
      if (data_a === 8'h00) zero_seen = 1;
      if (data_a === 8'h01 && first_return < 0) first_return = t + 1;
      bits[t] = out_a;
    end
    checks++;
    if (model_bad >= 0) begin errors++; $display("FAIL period_model: diverged at tick %0d got %h", model_bad, data_a); end
    checks++;
    if (bits[30:0] !== bits[61:31]) begin
      errors++;
      $display("FAIL period_repeat: got %h vs %h want equal", bits[30:0], bits[61:31]);
    end
    ones = 0;
    for (int t = 0; t < 31; t++) ones += int'(bits[t]);
    checks++;
    if (ones != 16) begin errors++; $display("FAIL period_ones: got %0d want 16", ones); end
    checks++;
    if (first_return != 31) begin errors++; $display("FAIL period_return: got %0d ticks want 31", first_return); end
    checks++;
    if (zero_seen != 0) begin errors++; $display("FAIL period_nonzero: got 00 state want never"); end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_seq [3] = '{8'h02, 8'h04, 8'h09};
    int bad_edge;
    repeat (20) @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_a !== 8'h01) begin errors++; $display("FAIL async_assert: got %h want 01", data_a); end
    #9;
    rst_n = 1'b1;
    bad_edge = 0;
    for (int i = 1; i <= 49; i++) begin
      @(posedge clk);
      #1;
      if (data_a !== 8'h01 && bad_edge == 0) bad_edge = i;
    end
    checks++;
    if (bad_edge != 0) begin errors++; $display("FAIL async_restart_hold: changed at edge %0d want 50", bad_edge); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) repeat (49) @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (data_a !== exp_seq[k]) begin errors++; $display("FAIL async_restart%0d: got %h want %h", k, data_a, exp_seq[k]); end
    end
  endtask

  task automatic test_clk_div1();
    logic [7:0] exp_seq [5] = '{8'h02, 8'h04, 8'h09, 8'h12, 8'h05};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (data_b !== exp_seq[k]) begin errors++; $display("FAIL div1_step%0d: got %h want %h", k, data_b, exp_seq[k]); end
    end
    checks++;
    if (out_b !== 1'b0) begin errors++; $display("FAIL div1_out_fun: got %b want 0", out_b); end
  endtask

  task automatic test_seed_zero();
    apply_reset();
    #1;
    checks++;
    if (data_z !== 8'h00) begin errors++; $display("FAIL zero_after_reset: got %h want 00", data_z); end
`ifdef MAIN_LOCKUP_RECOVERY_EN
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_z !== 8'h01) begin errors++; $display("FAIL zero_recover: got %h want 01", data_z); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_z !== 8'h02) begin errors++; $display("FAIL zero_recover_next: got %h want 02", data_z); end
`else
    begin
      int bad_edge = 0;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        if ((data_z !== 8'h00 || out_z !== 1'b0) && bad_edge == 0) bad_edge = i;
      end
      checks++;
      if (bad_edge != 0) begin
        errors++;
        $display("FAIL zero_lockup: got %h/%b at edge %0d want 00/0", data_z, out_z, bad_edge);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_period();
    test_async_reset();
    test_clk_div1();
    test_seed_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
